// File: rtl/fpu_mul_pkg.sv
// Shared widths, flag bit positions and special encodings for the multiplier
// writeback path.
package fpu_mul_pkg;
    localparam int FLAG_W  = 5;
    localparam int FLG_INV = 4;
    localparam int FLG_OVF = 3;
    localparam int FLG_UDF = 2;
    localparam int FLG_INX = 1;
    localparam int FLG_ZRO = 0;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] QNAN = 32'h7FFF_FFFF;
    localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;

    typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO with count, flush and modulo-DEPTH pointer wrap.
// Pushes while full without a simultaneous pop are dropped.
module fpu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    // Head reads as zero when empty so the output port is clean after reset/flush.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = inc(wr_q);
            if (do_pop)  rd_d = inc(rd_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/fpu_mul_wb.sv
// Writeback stage behind the non-stallable multiplier: tracks issued slots through
// its fixed latency, buffers results and throttles issue with FIFO credits.
module fpu_mul_wb
    import fpu_mul_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               issue_valid,
    input  logic [TAG_W-1:0]   issue_tag,
    output logic               issue_ready,
    input  logic               flush,
    input  logic               Sz,
    input  logic [EXP_W-1:0]   Ez,
    input  logic [MAN_W-1:0]   Mz,
    input  logic               invalid_flagex,
    input  logic               overflow_flagex,
    input  logic               underflow_flagex,
    input  logic               inexact_flagex,
    input  logic               zero_flagex,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [FP_W-1:0]    res_data,
    output logic [TAG_W-1:0]   res_tag,
    output logic [FLAG_W-1:0]  res_flags,
    output logic [FLAG_W-1:0]  sticky_flags,
    input  logic               clear_sticky,
    output logic               overrun_err
);
    localparam int ENT_W = TAG_W + FP_W + FLAG_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int IF_W  = $clog2(LATENCY+1);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    flags_t             sticky_q, sticky_d;
    logic               overrun_q, overrun_d;

    logic               fire, push, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [IF_W-1:0]    inflight;
    flags_t             mul_flags;
    logic [ENT_W-1:0]   wdata, head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + IF_W'(valid_q[i]);
    end

    // Credits come from registered state only; a pop frees its slot one cycle later.
    assign issue_ready = (32'(inflight) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH);
    assign fire        = issue_valid && issue_ready && !flush;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = fire;
        tag_d[0]   = issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
        if (flush) valid_d = '0;
    end

    always_comb begin
        mul_flags          = '0;
        mul_flags[FLG_INV] = invalid_flagex;
        mul_flags[FLG_OVF] = overflow_flagex;
        mul_flags[FLG_UDF] = underflow_flagex;
        mul_flags[FLG_INX] = inexact_flagex;
        mul_flags[FLG_ZRO] = zero_flagex;
    end

    assign push  = valid_q[LATENCY-1] && !flush;
    assign wdata = {tag_q[LATENCY-1], Sz, Ez, Mz, mul_flags};

    fpu_res_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign res_valid = !fifo_empty;
    assign res_tag   = head[ENT_W-1 -: TAG_W];
    assign res_data  = head[FLAG_W +: FP_W];
    assign res_flags = head[FLAG_W-1:0];
    assign pop       = res_valid && res_ready;

    // A pop coinciding with a clear keeps the popped entry's flags.
    always_comb begin
        sticky_d = sticky_q;
        if (pop)               sticky_d = (clear_sticky ? '0 : sticky_q) | res_flags;
        else if (clear_sticky) sticky_d = '0;
        overrun_d = overrun_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q   <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
            sticky_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
        end
    end

    assign sticky_flags = sticky_q;
    assign overrun_err  = overrun_q;
endmodule

// File: tb/tb_fpu_mul_wb.sv
// Bench for fpu_mul_wb: stands in for the multiplier and scores the DUT against
// a queue-based model of in-flight ops, buffered results and sticky flags.
module tb_fpu_mul_wb;
    import fpu_mul_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          issue_valid, issue_ready, flush;
    logic [TW-1:0] issue_tag;
    logic          Sz;
    logic [7:0]    Ez;
    logic [22:0]   Mz;
    logic          invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex;
    logic          res_valid, res_ready, clear_sticky, overrun_err;
    logic [31:0]   res_data;
    logic [TW-1:0] res_tag;
    logic [4:0]    res_flags, sticky_flags;

    fpu_mul_wb #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .flush(flush), .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flagex(invalid_flagex), .overflow_flagex(overflow_flagex),
        .underflow_flagex(underflow_flagex), .inexact_flagex(inexact_flagex),
        .zero_flagex(zero_flagex),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_flags(res_flags), .sticky_flags(sticky_flags),
        .clear_sticky(clear_sticky), .overrun_err(overrun_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic [4:0]    flags;
        int            cyc;
    } op_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
    } mres_t;

    op_t   inflight[$];
    op_t   fifo_m[$];
    mres_t mpipe[LAT];
    mres_t cur;
    logic [4:0] sticky_m;
    int cyc, n_chk, n_pass, acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic mres_t rand_res();
        mres_t r;
        r.data  = $urandom;
        r.flags = 5'($urandom);
        return r;
    endfunction

    // One clock: compare outputs, drive multiplier outputs, advance model across the edge.
    task automatic tick();
        bit  exp_rdy, fire, pop;
        op_t o;
        exp_rdy = (inflight.size() + fifo_m.size()) < DEPTH;
        check_eq("issue_ready", issue_ready, exp_rdy);
        check_eq("res_valid", res_valid, fifo_m.size() > 0);
        if (fifo_m.size() > 0) begin
            check_eq("res_data", res_data, fifo_m[0].data);
            check_eq("res_tag", res_tag, fifo_m[0].tag);
            check_eq("res_flags", res_flags, fifo_m[0].flags);
        end else begin
            check_eq("idle_head", {res_data, res_tag, res_flags}, 0);
        end
        check_eq("sticky", sticky_flags, sticky_m);
        check_eq("overrun", overrun_err, 0);

        {Sz, Ez, Mz} = mpipe[LAT-1].data;
        {invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex} = mpipe[LAT-1].flags;
        fire = issue_valid && exp_rdy && !flush;
        pop  = (fifo_m.size() > 0) && res_ready;

        @(posedge CLK);
        cyc++;
        for (int i = LAT-1; i > 0; i--) mpipe[i] = mpipe[i-1];
        mpipe[0] = fire ? cur : rand_res();

        if (pop) begin
            sticky_m = (clear_sticky ? 5'b0 : sticky_m) | fifo_m[0].flags;
            void'(fifo_m.pop_front());
        end else if (clear_sticky) begin
            sticky_m = 5'b0;
        end
        if (inflight.size() > 0 && inflight[0].cyc + LAT == cyc) begin
            o = inflight.pop_front();
            fifo_m.push_back(o);
        end
        if (fire) begin
            o.tag = issue_tag; o.data = cur.data; o.flags = cur.flags; o.cyc = cyc;
            inflight.push_back(o);
        end
        if (flush) begin
            inflight.delete();
            fifo_m.delete();
        end
        @(negedge CLK);
    endtask

    task automatic issue(input logic [TW-1:0] t, input logic [31:0] d, input logic [4:0] f);
        issue_valid = 1'b1; issue_tag = t; cur.data = d; cur.flags = f;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; sticky_m = '0;
        RST = 1'b0; issue_valid = 0; issue_tag = '0; flush = 0; res_ready = 0; clear_sticky = 0;
        {Sz, Ez, Mz} = '0;
        {invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex} = '0;
        cur = '0;
        for (int i = 0; i < LAT; i++) mpipe[i] = rand_res();
        #1;
        check_eq("rst_ready", issue_ready, 1);
        check_eq("rst_outs", {res_valid, res_data, res_tag, res_flags, sticky_flags, overrun_err}, 0);
        @(negedge CLK);
        RST = 1'b1;
        tick();

        // 3.0 x 2.0, tag 5
        res_ready = 1'b1;
        issue(4'd5, 32'h40C0_0000, 5'b0);
        repeat (6) tick();
        check_eq("mul_sticky0", sticky_flags, 5'b0);

        // back-pressure: only DEPTH issues may be accepted
        res_ready = 1'b0; issue_valid = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            issue_tag = TW'(acc); cur.data = 32'h3F80_0000 + acc; cur.flags = 5'b0;
            if (issue_ready) acc++;
            tick();
        end
        check_eq("bp_accepted", acc, DEPTH);
        issue_valid = 1'b0; res_ready = 1'b1;
        repeat (8) tick();

        // clear alone, then overflow
        clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
        issue(4'd1, PINF, 5'b01010);
        repeat (6) tick();
        check_eq("sticky_ovf", sticky_flags, 5'b01010);

        // inf x 0 popped together with a clear
        res_ready = 1'b0;
        issue(4'd2, QNAN, 5'b10000);
        repeat (4) tick();
        check_eq("nan_head_valid", res_valid, 1);
        res_ready = 1'b1; clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        check_eq("sticky_clr_pop", sticky_flags, 5'b10000);
        tick();

        // flush two in-flight ops, with an issue offered during the flush
        issue(4'd3, 32'h1111_1111, 5'b00001);
        issue(4'd4, 32'h2222_2222, 5'b00100);
        flush = 1'b1; issue(4'd6, 32'h3333_3333, 5'b00010); flush = 1'b0;
        check_eq("flush_ready", issue_ready, 1);
        repeat (6) tick();
        issue(4'd7, 32'h3F80_0000, 5'b0);
        repeat (6) tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_tag    = TW'($urandom);
            cur          = rand_res();
            res_ready    = ($urandom_range(0, 9) < 7);
            clear_sticky = ($urandom_range(0, 15) == 0);
            flush        = ($urandom_range(0, 31) == 0);
            tick();
        end
        issue_valid = 0; flush = 0; clear_sticky = 0;

        // async reset with ops in flight and one result buffered
        res_ready = 1'b0;
        issue(4'd8, 32'hAAAA_5555, 5'b11111);
        issue(4'd9, 32'h5555_AAAA, 5'b11111);
        issue(4'd10, 32'h1234_5678, 5'b11111);
        repeat (2) tick();
        check_eq("pre_rst_valid", res_valid, 1);
        #2 RST = 1'b0;
        #1;
        check_eq("arst_outs", {res_valid, res_data, res_tag, res_flags, sticky_flags, overrun_err}, 0);
        check_eq("arst_ready", issue_ready, 1);
        inflight.delete(); fifo_m.delete(); sticky_m = '0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        res_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
